uart_tx_shifter: RTL and testbench

//   Serialising datapath of the UART TX core; sits directly downstream of the TX state machine.
//   - Consumes the one-hot state, bit counter, baud strobe and parity trigger.
//   - Pops one byte from the TX FIFO per frame and computes its parity.
//   - Drives the serial line: start, data LSB-first, optional parity, stop.

---
 rtl/uart_tx_shifter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_shifter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_shifter.sv
// Serialising datapath of the UART TX core: pops one FIFO byte per frame, computes parity, drives Tx_o.
// Optional build macro UART_TX_SHIFTER_TMR_EN triplicates shift/parity/prev-state/Tx registers with majority voting.
module uart_tx_shifter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter logic        IDLE_LEVEL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p_BaudSig_i,
   input  logic [4:0]            State_i,
   input  logic [3:0]            BitCounter_i,
   input  logic                  p_ParityCalTrigger_i,
   input  logic                  ParityEnable_i,
   input  logic                  ParityOdd_i,
   input  logic [DATA_WIDTH-1:0] FifoData_i,
   output logic                  p_FifoRead_o,
   output logic                  Tx_o,
   output logic                  TxBusy_o,
   output logic                  StateErr_o
);

   localparam logic [4:0] ST_INTERVAL  = 5'b00001;
   localparam logic [4:0] ST_STARTBIT  = 5'b00010;
   localparam logic [4:0] ST_DATABITS  = 5'b00100;
   localparam logic [4:0] ST_PARITYBIT = 5'b01000;
   localparam logic [4:0] ST_STOPBIT   = 5'b10000;

   // Voted (or single-copy) register views and their next values
   logic [DATA_WIDTH-1:0] shift_q, shift_d, par_src;
   logic                  parity_q, parity_d;
   logic [4:0]            prev_state_q;
   logic                  tx_d;
   logic                  load_pend_r;
   logic                  state_legal;
   logic                  count_err;

   always_comb begin
      state_legal = 1'b0;
      case (State_i)
         ST_INTERVAL, ST_STARTBIT, ST_DATABITS, ST_PARITYBIT, ST_STOPBIT: state_legal = 1'b1;
         default: state_legal = 1'b0;
      endcase
   end

   assign count_err    = (State_i == ST_DATABITS) && (BitCounter_i > 4'(DATA_WIDTH - 1));
   assign p_FifoRead_o = !rst && (prev_state_q == ST_INTERVAL) && (State_i == ST_STARTBIT);
   // Parity trigger may land in the load cycle, when shift_q still holds the old byte
   assign par_src      = load_pend_r ? FifoData_i : shift_q;

   always_comb begin
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = IDLE_LEVEL;
      if (load_pend_r)
         shift_d = FifoData_i;
      else if ((State_i == ST_DATABITS) && p_BaudSig_i)
         shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      if (p_ParityCalTrigger_i && (State_i == ST_STARTBIT))
         parity_d = (^par_src) ^ ParityOdd_i;
      case (State_i)
         ST_INTERVAL:  tx_d = IDLE_LEVEL;
         ST_STARTBIT:  tx_d = ~IDLE_LEVEL;
         ST_DATABITS:  tx_d = shift_q[0];
         ST_PARITYBIT: tx_d = ParityEnable_i ? parity_q : IDLE_LEVEL;
         ST_STOPBIT:   tx_d = IDLE_LEVEL;
         default:      tx_d = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_pend_r <= 1'b0;
         TxBusy_o    <= 1'b0;
         StateErr_o  <= 1'b0;
      end else begin
         load_pend_r <= p_FifoRead_o;
         TxBusy_o    <= (State_i != ST_INTERVAL);
         if (!state_legal || count_err)
            StateErr_o <= 1'b1;
      end
   end

`ifdef UART_TX_SHIFTER_TMR_EN
   (* syn_preserve = 1 *) logic [DATA_WIDTH-1:0] shift_r0, shift_r1, shift_r2;
   (* syn_preserve = 1 *) logic                  parity_r0, parity_r1, parity_r2;
   (* syn_preserve = 1 *) logic [4:0]            prev_state_r0, prev_state_r1, prev_state_r2;
   (* syn_preserve = 1 *) logic                  tx_r0, tx_r1, tx_r2;

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r0      <= '0;
         shift_r1      <= '0;
         shift_r2      <= '0;
         parity_r0     <= 1'b0;
         parity_r1     <= 1'b0;
         parity_r2     <= 1'b0;
         prev_state_r0 <= ST_INTERVAL;
         prev_state_r1 <= ST_INTERVAL;
         prev_state_r2 <= ST_INTERVAL;
         tx_r0         <= IDLE_LEVEL;
         tx_r1         <= IDLE_LEVEL;
         tx_r2         <= IDLE_LEVEL;
      end else begin
         shift_r0      <= shift_d;
         shift_r1      <= shift_d;
         shift_r2      <= shift_d;
         parity_r0     <= parity_d;
         parity_r1     <= parity_d;
         parity_r2     <= parity_d;
         prev_state_r0 <= State_i;
         prev_state_r1 <= State_i;
         prev_state_r2 <= State_i;
         tx_r0         <= tx_d;
         tx_r1         <= tx_d;
         tx_r2         <= tx_d;
      end
   end

   // Bitwise 2-of-3 majority: a single upset copy is outvoted
   assign shift_q      = (shift_r0 & shift_r1) | (shift_r0 & shift_r2) | (shift_r1 & shift_r2);
   assign parity_q     = (parity_r0 & parity_r1) | (parity_r0 & parity_r2) | (parity_r1 & parity_r2);
   assign prev_state_q = (prev_state_r0 & prev_state_r1) | (prev_state_r0 & prev_state_r2) |
                         (prev_state_r1 & prev_state_r2);
   assign Tx_o         = (tx_r0 & tx_r1) | (tx_r0 & tx_r2) | (tx_r1 & tx_r2);
`else
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  parity_r;
   logic [4:0]            prev_state_r;
   logic                  tx_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r      <= '0;
         parity_r     <= 1'b0;
         prev_state_r <= ST_INTERVAL;
         tx_r         <= IDLE_LEVEL;
      end else begin
         shift_r      <= shift_d;
         parity_r     <= parity_d;
         prev_state_r <= State_i;
         tx_r         <= tx_d;
      end
   end

   assign shift_q      = shift_r;
   assign parity_q     = parity_r;
   assign prev_state_q = prev_state_r;
   assign Tx_o         = tx_r;
`endif

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Self-checking bench for uart_tx_shifter: models the TX FSM and FIFO, scoreboards serial bits per bit period.
module tb_uart_tx_shifter;

   localparam logic [4:0] S_INT = 5'b00001;
   localparam logic [4:0] S_STA = 5'b00010;
   localparam logic [4:0] S_DAT = 5'b00100;
   localparam logic [4:0] S_PAR = 5'b01000;
   localparam logic [4:0] S_STP = 5'b10000;

   logic       clk = 1'b0;
   logic       rst;
   logic       p_BaudSig_i;
   logic [4:0] State_i;
   logic [3:0] BitCounter_i;
   logic       p_ParityCalTrigger_i;
   logic       ParityEnable_i;
   logic       ParityOdd_i;
   logic [7:0] FifoData_i;
   logic       p_FifoRead_o;
   logic       Tx_o;
   logic       TxBusy_o;
   logic       StateErr_o;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         rd_cnt   = 0;
   logic [7:0] fifo_q[$];
   logic [0:0] exp_q[$];

   uart_tx_shifter #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .p_BaudSig_i          (p_BaudSig_i),
      .State_i              (State_i),
      .BitCounter_i         (BitCounter_i),
      .p_ParityCalTrigger_i (p_ParityCalTrigger_i),
      .ParityEnable_i       (ParityEnable_i),
      .ParityOdd_i          (ParityOdd_i),
      .FifoData_i           (FifoData_i),
      .p_FifoRead_o         (p_FifoRead_o),
      .Tx_o                 (Tx_o),
      .TxBusy_o             (TxBusy_o),
      .StateErr_o           (StateErr_o)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // One clock: observe the pop strobe before the edge, answer with FIFO data after it
   task automatic tick();
      logic rd_now;
      #1;
      rd_now = p_FifoRead_o;
      if (rd_now) rd_cnt++;
      @(posedge clk);
      #1;
      if (rd_now) begin
         n_checks++;
         if (fifo_q.size() == 0) begin
            n_fail++;
            $display("FAIL fifo_underflow: pop strobe seen, expected none (queue empty)");
            FifoData_i = 8'($urandom_range(0, 255));
         end else begin
            FifoData_i = fifo_q.pop_front();
         end
      end else begin
         FifoData_i = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic check_bit(input string name);
      logic [0:0] exp_bit;
      exp_bit = exp_q.pop_front();
      n_checks++;
      if (Tx_o !== exp_bit) begin
         n_fail++;
         $display("FAIL %s: Tx_o=%b expected %b", name, Tx_o, exp_bit);
      end
      n_checks++;
      if (TxBusy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_busy: TxBusy_o=%b expected 1", name, TxBusy_o);
      end
   endtask

   task automatic bit_period(input logic [4:0] st, input logic [3:0] cnt, input int baud,
                             input logic exp_bit, input logic trig_en, input string name);
      exp_q.push_back(exp_bit);
      State_i      = st;
      BitCounter_i = cnt;
      for (int c = 0; c < baud; c++) begin
         p_BaudSig_i          = (c == baud - 1);
         p_ParityCalTrigger_i = trig_en && (c == baud - 1);
         tick();
         if (c == baud / 2) check_bit(name);
      end
      p_BaudSig_i          = 1'b0;
      p_ParityCalTrigger_i = 1'b0;
   endtask

   task automatic check_idle(input string name);
      n_checks++;
      if (Tx_o !== 1'b1 || TxBusy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: Tx_o=%b TxBusy_o=%b expected 1 0", name, Tx_o, TxBusy_o);
      end
   endtask

   // exp_par < 0 : parity disabled; otherwise the independently derived parity bit
   task automatic send_frame(input logic [7:0] d, input int exp_par, input logic podd, input int baud,
                             input int idle_ticks, input int abort_bit, input logic do_flip);
      int rd0;
      rd0            = rd_cnt;
      fifo_q.push_back(d);
      ParityEnable_i = (exp_par >= 0);
      ParityOdd_i    = podd;
      State_i        = S_INT;
      for (int i = 0; i < idle_ticks; i++) tick();
      bit_period(S_STA, 4'd0, baud, 1'b0, 1'b1, "start_bit");
      for (int b = 0; b < 8; b++) begin
         if (b == abort_bit) begin
            exp_q.push_back(d[b]);
            State_i = S_DAT;
            BitCounter_i = 4'(b);
            for (int c = 0; c <= baud / 2; c++) tick();
            check_bit("pre_abort_bit");
            rst = 1'b1;
            tick();
            check_idle("abort_idle");
            rst     = 1'b0;
            State_i = S_INT;
            tick();
            return;
         end
`ifdef UART_TX_SHIFTER_TMR_EN
         if (do_flip && b == 2) dut.shift_r1[3] = ~dut.shift_r1[3];
`else
         if (do_flip && b == 2) $display("note: TMR upset skipped in single-register build");
`endif
         bit_period(S_DAT, 4'(b), baud, d[b], 1'b0, "data_bit");
      end
      if (exp_par >= 0) bit_period(S_PAR, 4'd0, baud, exp_par[0], 1'b0, "parity_bit");
      bit_period(S_STP, 4'd0, baud, 1'b1, 1'b0, "stop_bit");
      n_checks++;
      if (rd_cnt - rd0 != 1) begin
         n_fail++;
         $display("FAIL read_pulses: got %0d expected 1", rd_cnt - rd0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; State_i = S_STA;
      #1;
      n_checks++;
      if (p_FifoRead_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pop: p_FifoRead_o=%b expected 0", p_FifoRead_o);
      end
      tick();
      State_i = S_INT;
      tick();
      check_idle("reset_idle");
      n_checks++;
      if (StateErr_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: StateErr_o=%b expected 0", StateErr_o);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      send_frame(8'h55, -1, 1'b0, 16, 3, -1, 1'b0);
      State_i = S_INT;
      tick();
      check_idle("basic_end_idle");
   endtask

   task automatic test_parity();
      send_frame(8'hA7, 1, 1'b0, 16, 2, -1, 1'b0);
      send_frame(8'hA7, 0, 1'b1, 16, 2, -1, 1'b0);
      // trigger in the load cycle: parity must come from the fresh FIFO byte
      send_frame(8'h01, 1, 1'b0, 2, 2, -1, 1'b0);
      State_i = S_INT;
      tick();
   endtask

   task automatic test_back_to_back();
      int rd0;
      rd0 = rd_cnt;
      send_frame(8'h00, 1, 1'b1, 8, 1, -1, 1'b0);
      send_frame(8'hFF, 1, 1'b1, 8, 1, -1, 1'b0);
      State_i = S_INT;
      tick();
      check_idle("b2b_end_idle");
      n_checks++;
      if (rd_cnt - rd0 != 2) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d expected 2", rd_cnt - rd0);
      end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'hC3, -1, 1'b0, 16, 2, 3, 1'b0);
      send_frame(8'h3C, -1, 1'b0, 16, 2, -1, 1'b0);
      State_i = S_INT;
      tick();
   endtask

   task automatic test_state_err();
      State_i = 5'b00110;
      tick();
      n_checks++;
      if (Tx_o !== 1'b1 || StateErr_o !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_state: Tx_o=%b StateErr_o=%b expected 1 1", Tx_o, StateErr_o);
      end
      State_i = S_INT;
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (StateErr_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: StateErr_o=%b expected 1", StateErr_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (StateErr_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: StateErr_o=%b expected 0", StateErr_o);
      end
      State_i = S_DAT; BitCounter_i = 4'd8;
      tick();
      n_checks++;
      if (StateErr_o !== 1'b1) begin
         n_fail++;
         $display("FAIL count_range: StateErr_o=%b expected 1", StateErr_o);
      end
      BitCounter_i = 4'd0; State_i = S_INT; rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_tmr_upset();
      send_frame(8'h55, -1, 1'b0, 16, 2, -1, 1'b1);
      State_i = S_INT;
      tick();
   endtask

   initial begin
      rst = 1'b1; p_BaudSig_i = 1'b0; State_i = S_INT; BitCounter_i = 4'd0;
      p_ParityCalTrigger_i = 1'b0; ParityEnable_i = 1'b0; ParityOdd_i = 1'b0; FifoData_i = 8'h00;
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      test_state_err();
      test_tmr_upset();
      n_checks++;
      if (exp_q.size() != 0 || fifo_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftovers: exp_q=%0d fifo_q=%0d expected 0 0", exp_q.size(), fifo_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
